// File: rtl/exmem_arb_pkg.sv
// Shared types and constants for the two-port external memory arbiter.
package exmem_arb_pkg;

  localparam int unsigned NPORTS        = 2;
  localparam int unsigned DEFAULT_WIDTH = 32;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_e;

  typedef logic [$clog2(NPORTS)-1:0] port_idx_t;

endpackage

// File: rtl/exmem_arbiter_if.sv
// Requester-side handshake and memory-side bus of the external memory arbiter.
interface exmem_arbiter_if #(
  parameter int unsigned WIDTH = exmem_arb_pkg::DEFAULT_WIDTH
);

  logic             req0, req1;
  logic             we0, we1;
  logic [WIDTH-1:0] adr0, adr1;
  logic [WIDTH-1:0] wdata0, wdata1;
  logic             gnt0, gnt1;
  logic             rvalid0, rvalid1;
  logic [WIDTH-1:0] rdata;
  logic             memwrite;
  logic [WIDTH-1:0] adr;
  logic [WIDTH-1:0] writedata;
  logic [WIDTH-1:0] memdata;

  modport slave (
    input  req0, req1, we0, we1, adr0, adr1, wdata0, wdata1, memdata,
    output gnt0, gnt1, rvalid0, rvalid1, rdata, memwrite, adr, writedata
  );

  modport master (
    output req0, req1, we0, we1, adr0, adr1, wdata0, wdata1, memdata,
    input  gnt0, gnt1, rvalid0, rvalid1, rdata, memwrite, adr, writedata
  );

endinterface

// File: rtl/exmem_arb_rr_pick.sv
// Combinational 2-way round-robin picker: on a tie the port that did not win last is chosen.
module exmem_arb_rr_pick
  import exmem_arb_pkg::*;
(
  input  logic [NPORTS-1:0] elig,
  input  port_idx_t         last_owner,
  output port_idx_t         winner,
  output logic              any
);

  always_comb begin
    any = |elig;
    if (&elig) begin
      winner = ~last_owner;
    end else if (elig[1]) begin
      winner = 1'b1;
    end else begin
      winner = 1'b0;
    end
  end

endmodule

// File: rtl/exmem_arbiter.sv
// Two-requester arbiter for the single-ported external memory (port 0 = core, port 1 = loader).
// Optional grant counters grants0/grants1 are built when EXMEM_ARB_STATS_EN is defined.
module exmem_arbiter
  import exmem_arb_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic        clk,
  input  logic        reset,
  exmem_arbiter_if.slave bus
`ifdef EXMEM_ARB_STATS_EN
  ,
  output logic [31:0] grants0,
  output logic [31:0] grants1
`endif
);

  state_e            state_q, state_d;
  port_idx_t         owner_q, owner_d;
  port_idx_t         last_owner_q, last_owner_d;
  logic [NPORTS-1:0] gnt_q, gnt_d;
  logic [NPORTS-1:0] rvalid_q, rvalid_d;
  logic              memwrite_q, memwrite_d;
  logic [WIDTH-1:0]  adr_q, adr_d;
  logic [WIDTH-1:0]  writedata_q, writedata_d;
  logic [WIDTH-1:0]  rdata_q, rdata_d;

  logic [NPORTS-1:0] elig;
  port_idx_t         winner;
  logic              any;

  // A port whose grant is on the bus right now is not eligible, so a held req is not re-served.
  assign elig = {bus.req1 & ~gnt_q[1], bus.req0 & ~gnt_q[0]};

  exmem_arb_rr_pick u_pick (
    .elig       (elig),
    .last_owner (last_owner_q),
    .winner     (winner),
    .any        (any)
  );

  always_comb begin
    state_d      = IDLE;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    gnt_d        = '0;
    rvalid_d     = '0;
    memwrite_d   = 1'b0;
    adr_d        = adr_q;
    writedata_d  = writedata_q;
    rdata_d      = rdata_q;

    if (state_q == ACCESS && !memwrite_q) begin
      rdata_d           = bus.memdata;
      rvalid_d[owner_q] = 1'b1;
    end

    if (any) begin
      state_d        = ACCESS;
      owner_d        = winner;
      last_owner_d   = winner;
      gnt_d[winner]  = 1'b1;
      memwrite_d     = winner ? bus.we1    : bus.we0;
      adr_d          = winner ? bus.adr1   : bus.adr0;
      writedata_d    = winner ? bus.wdata1 : bus.wdata0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      owner_q      <= '0;
      last_owner_q <= 1'b1;
      gnt_q        <= '0;
      rvalid_q     <= '0;
      memwrite_q   <= 1'b0;
      adr_q        <= '0;
      writedata_q  <= '0;
      rdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      gnt_q        <= gnt_d;
      rvalid_q     <= rvalid_d;
      memwrite_q   <= memwrite_d;
      adr_q        <= adr_d;
      writedata_q  <= writedata_d;
      rdata_q      <= rdata_d;
    end
  end

  assign bus.gnt0      = gnt_q[0];
  assign bus.gnt1      = gnt_q[1];
  assign bus.rvalid0   = rvalid_q[0];
  assign bus.rvalid1   = rvalid_q[1];
  assign bus.rdata     = rdata_q;
  assign bus.memwrite  = memwrite_q;
  assign bus.adr       = adr_q;
  assign bus.writedata = writedata_q;

`ifdef EXMEM_ARB_STATS_EN
  logic [31:0] grants0_q, grants0_d;
  logic [31:0] grants1_q, grants1_d;

  // Counted alongside the registered grant, so the count already includes a grant on the bus.
  always_comb begin
    grants0_d = grants0_q + {31'd0, gnt_d[0]};
    grants1_d = grants1_q + {31'd0, gnt_d[1]};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      grants0_q <= '0;
      grants1_q <= '0;
    end else begin
      grants0_q <= grants0_d;
      grants1_q <= grants1_d;
    end
  end

  assign grants0 = grants0_q;
  assign grants1 = grants1_q;
`endif

endmodule

// File: tb/tb_exmem_arbiter.sv
// Directed self-checking bench for exmem_arbiter with a small word-addressed RAM behind the bus.
module tb_exmem_arbiter;

  logic clk;
  logic reset;
  logic preload;
  int   checks;
  int   failures;

  logic [31:0] ram [0:15];

  exmem_arbiter_if #(.WIDTH(32)) bus ();

`ifdef EXMEM_ARB_STATS_EN
  logic [31:0] grants0;
  logic [31:0] grants1;
`endif

  exmem_arbiter #(.WIDTH(32)) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus)
`ifdef EXMEM_ARB_STATS_EN
    ,
    .grants0 (grants0),
    .grants1 (grants1)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign bus.memdata = ram[bus.adr[5:2]];

  always @(posedge clk) begin
    if (bus.memwrite) begin
      ram[bus.adr[5:2]] <= bus.writedata;
    end else if (preload) begin
      ram[0] <= 32'h2002_0005;
      ram[1] <= 32'h1111_1111;
      ram[2] <= 32'h2222_2222;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_gnt0"}, bus.gnt0, 0);
    chk({tag, "_gnt1"}, bus.gnt1, 0);
    chk({tag, "_rvalid0"}, bus.rvalid0, 0);
    chk({tag, "_rvalid1"}, bus.rvalid1, 0);
    chk({tag, "_memwrite"}, bus.memwrite, 0);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    preload  = 1'b1;
    bus.req0 = 1'b0; bus.we0 = 1'b0; bus.adr0 = '0; bus.wdata0 = '0;
    bus.req1 = 1'b0; bus.we1 = 1'b0; bus.adr1 = '0; bus.wdata1 = '0;

    tick;
    tick;
    preload = 1'b0;
    chk_idle_outputs("rst");
    chk("rst_adr", bus.adr, 0);
    chk("rst_writedata", bus.writedata, 0);
    chk("rst_rdata", bus.rdata, 0);
`ifdef EXMEM_ARB_STATS_EN
    chk("rst_grants0", grants0, 0);
    chk("rst_grants1", grants1, 0);
`endif

    // Both ports read right out of reset: port 0 wins the first tie.
    reset = 1'b0;
    bus.req0 = 1'b1; bus.we0 = 1'b0; bus.adr0 = 32'd4;
    bus.req1 = 1'b1; bus.we1 = 1'b0; bus.adr1 = 32'd8;
    tick;
    chk("both_c1_gnt0", bus.gnt0, 1);
    chk("both_c1_gnt1", bus.gnt1, 0);
    chk("both_c1_adr", bus.adr, 4);
    chk("both_c1_memwrite", bus.memwrite, 0);
    bus.req0 = 1'b0;
    tick;
    chk("both_c2_gnt0", bus.gnt0, 0);
    chk("both_c2_gnt1", bus.gnt1, 1);
    chk("both_c2_adr", bus.adr, 8);
    chk("both_c2_rvalid0", bus.rvalid0, 1);
    chk("both_c2_rvalid1", bus.rvalid1, 0);
    chk("both_c2_rdata", bus.rdata, 32'h1111_1111);
    bus.req1 = 1'b0;
    tick;
    chk("both_c3_gnt1", bus.gnt1, 0);
    chk("both_c3_rvalid0", bus.rvalid0, 0);
    chk("both_c3_rvalid1", bus.rvalid1, 1);
    chk("both_c3_rdata", bus.rdata, 32'h2222_2222);
    tick;
    chk_idle_outputs("both_c4");
    chk("both_c4_rdata_hold", bus.rdata, 32'h2222_2222);

    // Port 0 write of 7 to byte address 20 (word 5).
    bus.req0 = 1'b1; bus.we0 = 1'b1; bus.adr0 = 32'd20; bus.wdata0 = 32'd7;
    tick;
    chk("wr0_gnt0", bus.gnt0, 1);
    chk("wr0_memwrite", bus.memwrite, 1);
    chk("wr0_adr", bus.adr, 20);
    chk("wr0_writedata", bus.writedata, 7);
    bus.req0 = 1'b0; bus.we0 = 1'b0;
    tick;
    chk("wr0_done_gnt0", bus.gnt0, 0);
    chk("wr0_done_memwrite", bus.memwrite, 0);
    chk("wr0_no_rvalid0", bus.rvalid0, 0);
    chk("wr0_ram5", ram[5], 7);
    chk("wr0_rdata_hold", bus.rdata, 32'h2222_2222);

    // Port 1 read of the preloaded word 0.
    bus.req1 = 1'b1; bus.we1 = 1'b0; bus.adr1 = 32'd0;
    tick;
    chk("rd1_gnt1", bus.gnt1, 1);
    chk("rd1_adr", bus.adr, 0);
    chk("rd1_rvalid1_early", bus.rvalid1, 0);
    bus.req1 = 1'b0;
    tick;
    chk("rd1_rvalid1", bus.rvalid1, 1);
    chk("rd1_rdata", bus.rdata, 32'h2002_0005);

    // Continuous contention: last owner was port 1, so grants go 0,1,0,1,...
    bus.req0 = 1'b1; bus.we0 = 1'b0; bus.adr0 = 32'd4;
    bus.req1 = 1'b1; bus.we1 = 1'b0; bus.adr1 = 32'd8;
    for (int i = 0; i < 8; i++) begin
      tick;
      chk($sformatf("alt%0d_gnt0", i), bus.gnt0, (i % 2 == 0) ? 1 : 0);
      chk($sformatf("alt%0d_gnt1", i), bus.gnt1, (i % 2 == 1) ? 1 : 0);
      chk($sformatf("alt%0d_rvalid0", i), bus.rvalid0, (i % 2 == 1) ? 1 : 0);
      chk($sformatf("alt%0d_rvalid1", i), bus.rvalid1, (i > 0 && i % 2 == 0) ? 1 : 0);
    end
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    tick;
    chk("alt_end_gnt0", bus.gnt0, 0);
    chk("alt_end_gnt1", bus.gnt1, 0);
    chk("alt_end_rvalid1", bus.rvalid1, 1);
    chk("alt_end_rdata", bus.rdata, 32'h2222_2222);

    // Single port holding req is served at most every other cycle.
    bus.req0 = 1'b1; bus.we0 = 1'b0; bus.adr0 = 32'd0;
    for (int i = 0; i < 4; i++) begin
      tick;
      chk($sformatf("hold%0d_gnt0", i), bus.gnt0, (i % 2 == 0) ? 1 : 0);
      chk($sformatf("hold%0d_rvalid0", i), bus.rvalid0, (i % 2 == 1) ? 1 : 0);
    end
    bus.req0 = 1'b0;
    tick;
    chk_idle_outputs("hold_end");
`ifdef EXMEM_ARB_STATS_EN
    chk("pre_rst_grants0", grants0, 8);
    chk("pre_rst_grants1", grants1, 6);
`endif

    // Reset lands in the ACCESS cycle of a port 1 write: write commits, outputs clear.
    bus.req1 = 1'b1; bus.we1 = 1'b1; bus.adr1 = 32'd40; bus.wdata1 = 32'h55;
    tick;
    chk("rstwr_gnt1", bus.gnt1, 1);
    chk("rstwr_memwrite", bus.memwrite, 1);
    chk("rstwr_adr", bus.adr, 40);
    reset = 1'b1;
    bus.req1 = 1'b0; bus.we1 = 1'b0;
    bus.req0 = 1'b1; bus.we0 = 1'b0; bus.adr0 = 32'd4;
    tick;
    chk("rstwr_ram10", ram[10], 32'h55);
    chk_idle_outputs("rstwr_after");
    chk("rstwr_adr0", bus.adr, 0);
    chk("rstwr_writedata0", bus.writedata, 0);
    chk("rstwr_rdata0", bus.rdata, 0);
`ifdef EXMEM_ARB_STATS_EN
    chk("rstwr_grants0", grants0, 0);
    chk("rstwr_grants1", grants1, 0);
`endif
    tick;
    chk("rst_req_ignored_gnt0", bus.gnt0, 0);
    reset = 1'b0;
    tick;
    chk("post_rst_gnt0", bus.gnt0, 1);
    bus.req0 = 1'b0;
    tick;
    chk("post_rst_rvalid0", bus.rvalid0, 1);
    chk("post_rst_rdata", bus.rdata, 32'h1111_1111);

    // Last owner is now port 0, so contention starts with port 1.
    bus.req0 = 1'b1; bus.adr0 = 32'd0;
    bus.req1 = 1'b1; bus.we1 = 1'b0; bus.adr1 = 32'd4;
    for (int i = 0; i < 4; i++) begin
      tick;
      chk($sformatf("alt2_%0d_gnt1", i), bus.gnt1, (i % 2 == 0) ? 1 : 0);
      chk($sformatf("alt2_%0d_gnt0", i), bus.gnt0, (i % 2 == 1) ? 1 : 0);
    end
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    tick;
    for (int n = 0; n < 3; n++) begin
      bus.req1 = 1'b1; bus.adr1 = 32'd8;
      tick;
      chk($sformatf("solo1_%0d_gnt1", n), bus.gnt1, 1);
      bus.req1 = 1'b0;
      tick;
      chk($sformatf("solo1_%0d_rdata", n), bus.rdata, 32'h2222_2222);
    end
`ifdef EXMEM_ARB_STATS_EN
    chk("stats_grants0", grants0, 3);
    chk("stats_grants1", grants1, 5);
    reset = 1'b1;
    tick;
    reset = 1'b0;
    chk("stats_clr_grants0", grants0, 0);
    chk("stats_clr_grants1", grants1, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/exmem_arbiter.md
# exmem_arbiter

Two-requester arbiter that shares the single-ported 32-bit external memory between the `mips32` core (port 0) and a loader/debug master (port 1). It sits between the requesters and the memory's `memwrite`/`adr`/`writedata`/`memdata` port. It serialises accesses through a registered two-state sequencer and grants contended cycles round-robin. It returns registered read data with a one-cycle valid pulse.

## Interface
- `WIDTH`, 32, data and address width in bits.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `req0`, `req1`  in  1  access request; held high with `we`/`adr`/`wdata` stable until the matching `gnt` is seen.
- `we0`, `we1`  in  1  1 = write, 0 = read.
- `adr0`, `adr1`  in  WIDTH  byte address; the memory uses word index `adr>>2`.
- `wdata0`, `wdata1`  in  WIDTH  write data.
- `gnt0`, `gnt1`  out  1  high for exactly one cycle, the cycle the port's access is on the memory bus.
- `rvalid0`, `rvalid1`  out  1  one-cycle pulse; `rdata` is valid for that port.
- `rdata`  out  WIDTH  registered read data, shared by both ports.
- `memwrite`  out  1  memory write strobe.
- `adr`  out  WIDTH  memory address.
- `writedata`  out  WIDTH  memory write data.
- `memdata`  in  WIDTH  combinational memory read data.

## Operation
- States:
  - IDLE: memory bus parked, `memwrite`=0.
  - ACCESS: one owner drives the bus.
- Eligible request: `reqN`=1 and `gntN`=0 in the current cycle. A request held through its own grant cycle is not re-served.
- IDLE with ≥1 eligible request → ACCESS. At the edge, latch `owner`, `adr`, `writedata`, `memwrite`=`weN`.
- ACCESS with an eligible request → ACCESS for the new winner. Back-to-back from the other port is allowed. Otherwise → IDLE.
- Round-robin on tie: grant the port ≠ `last_owner`. `last_owner` updates on every grant.
- Read completion: at the edge ending ACCESS, `rdata` ← `memdata` and `rvalidN` ← 1 for the owner if it was a read.
- Write completion: the memory commits on the same edge. `rvalid` is not asserted for writes.
- `rdata` holds its value until the next read completes.

## Timing
- Reset values:
  - state=IDLE, `last_owner`=1 (port 0 wins the first tie).
  - `gnt0`/`gnt1`/`rvalid0`/`rvalid1`/`memwrite`=0.
  - `adr`/`writedata`/`rdata`=0.
- Request seen in cycle N → `gnt` and bus drive in cycle N+1 (if uncontended) → `rvalid` in cycle N+2.
- A single port achieves at most one access every 2 cycles. Two alternating ports achieve one access per cycle.
- Worst-case wait under contention is one extra access (2 cycles).
- Requester may drop `req` at the edge ending its `gnt` cycle. Changing `adr`/`wdata`/`we` before `gnt` is a protocol violation; the value at the latching edge is used.
- Reset asserted during ACCESS: the write in that cycle still commits (the memory samples `memwrite` at the same edge). Its `rvalid` is suppressed. All outputs take reset values the next cycle.
- `req` during reset is ignored. The first grant is possible in the cycle after reset deasserts plus one.

## Configuration
- `EXMEM_ARB_STATS_EN` defined: adds outputs `grants0`, `grants1` (32-bit each).
  - Each increments by 1 on every grant to its port.
  - Each wraps 0xFFFFFFFF → 0.
  - Each clears on `reset`.
- Undefined: the counters and ports are absent. All other behaviour is identical.

## Structure
- Package `exmem_arb_pkg`: state enum (IDLE, ACCESS), `NPORTS`=2, port-index type, `WIDTH` default constant.
- One sub-module: `exmem_arb_rr_pick`, a combinational 2-way round-robin picker. Inputs are the eligible vector and `last_owner`; outputs are `winner` and `any`.
- Sequencer, bus registers and stats counters live in `exmem_arbiter`.

## Test plan
- Port 0 write: `adr0`=20, `wdata0`=7 → `gnt0` in cycle N+1 with `memwrite`=1, `adr`=20, `writedata`=7; RAM word 5 = 7; no `rvalid0`.
- Port 1 read of word preloaded 0x20020005 at `adr1`=0 → `gnt1` at N+1, `rvalid1` at N+2, `rdata`=0x20020005.
- Both request from reset (reads at `adr0`=4, `adr1`=8) → `gnt0` at N+1, `gnt1` at N+2, `rvalid0` at N+2, `rvalid1` at N+3.
- Both hold `req` continuously for 8 cycles after each grant → grants strictly alternate 0,1,0,1; no port waits more than 2 cycles.
- Reset asserted in the ACCESS cycle of a write of 0x55 to `adr1`=40 → RAM word 10 = 0x55; no `rvalid`; next cycle all outputs at reset values.
- With `EXMEM_ARB_STATS_EN`: 3 port-0 and 5 port-1 accesses → `grants0`=3, `grants1`=5; after reset both are 0.
